// File: rtl/flash_pkg.sv
// Shared constants for the flash operation sequencer: FSM encoding,
// request type codes, unlock key, command bit positions, range helper.
package flash_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_ERASE_REQ = 3'd2;
  localparam logic [2:0] ST_RD_LO     = 3'd3;
  localparam logic [2:0] ST_RD_HI     = 3'd4;
  localparam logic [2:0] ST_WR_REQ    = 3'd5;
  localparam logic [2:0] ST_RSP_WAIT  = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  localparam logic REQ_WRITE = 1'b0;
  localparam logic REQ_ERASE = 1'b1;

  localparam logic [17:0] UNLOCK_KEY = 18'hDAF0;

  localparam int CMD_WR_BIT = 0;
  localparam int CMD_ER_BIT = 1;

  // True when a write of len words starting at addr runs past 2^18.
  function automatic logic rangeBad(
    input logic [17:0] addr,
    input logic [5:0]  len
  );
    logic [18:0] endAddr;
    endAddr = {1'b0, addr} + {13'd0, len};
    return endAddr > 19'h40000;
  endfunction

endpackage

// File: rtl/flash_op_timer.sv
// Per-command watchdog: Clear restarts at 0, Enable counts up,
// Expired once the count reaches TIMEOUT_CYCLES. Ports: Clock, Reset.
module flash_op_timer
  import flash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  logic [31:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count <= '0;
    end else if (Enable && !Expired) begin
      count <= count + 32'd1;
    end
  end

  assign Expired = count >= TIMEOUT_CYCLES;

endmodule

// File: rtl/flash_op_sequencer.sv
// Flash op sequencer: accepts unlocked write/erase commands, validates them,
// reads 16-bit staging RAM pairs into 32-bit words and issues flash requests.
// Ports: FlashOp* command in, FlashCmdAck/Busy/Error status, BufRd* staging
// RAM, FlashReq*/FlashRsp* flash handshake. Option: FLASH_OP_TIMEOUT_EN.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [17:0] FlashOpAddr,
  input  logic [5:0]  FlashOpLen,
  input  logic        FlashOpUnlock,
  input  logic        FlashOpWr,
  input  logic        FlashOpEr,
  output logic        FlashCmdAck,
  output logic        FlashBusy,
  output logic        FlashError,
  output logic [6:0]  BufRdAddress,
  input  logic [15:0] BufRdData,
  output logic        FlashReqValid,
  output logic        FlashReqType,
  output logic [17:0] FlashReqAddr,
  output logic [31:0] FlashReqData,
  input  logic        FlashReqReady,
  input  logic        FlashRspDone,
  input  logic        FlashRspFail
);

  if (TIMEOUT_CYCLES == 0) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [1:0]  cmd;
  logic [17:0] addrReg;
  logic [5:0]  lenReg;
  logic [6:0]  idx;
  logic [15:0] loReg;
  logic [15:0] hiReg;
  logic        errReg;
  logic        accept;
  logic        cmdBad;
  logic        lastWord;
  logic        reqState;
  logic        waitState;
  logic        rspSeen;
  logic        timeout;
  logic        timedOut;

  assign accept = (state == ST_IDLE) && FlashOpUnlock
                  && (FlashOpWr || FlashOpEr);

  assign cmdBad = (&cmd)
    || (cmd[CMD_WR_BIT]
        && ((lenReg == 6'd0) || rangeBad(addrReg, lenReg)));

  assign lastWord = (idx + 7'd1) == {1'b0, lenReg};

  assign reqState = (state == ST_ERASE_REQ)
                    || (state == ST_WR_REQ);
  assign waitState = reqState || (state == ST_RSP_WAIT);
  assign rspSeen = (state == ST_RSP_WAIT) && FlashRspDone;

`ifdef FLASH_OP_TIMEOUT_EN
  logic enterWait;

  // Restart the watchdog on every entry into a waiting state.
  assign enterWait = (stateNext != state)
    && ((stateNext == ST_ERASE_REQ)
        || (stateNext == ST_WR_REQ)
        || (stateNext == ST_RSP_WAIT));

  flash_op_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimer (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (enterWait),
    .Enable (waitState),
    .Expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A response arriving on the expiry cycle still wins.
  assign timedOut = waitState && timeout && !rspSeen;

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:
        if (accept) stateNext = ST_CHECK;
      ST_CHECK:
        if (cmdBad) stateNext = ST_DONE;
        else if (cmd[CMD_ER_BIT]) stateNext = ST_ERASE_REQ;
        else stateNext = ST_RD_LO;
      ST_ERASE_REQ, ST_WR_REQ:
        if (timedOut) stateNext = ST_DONE;
        else if (FlashReqReady) stateNext = ST_RSP_WAIT;
      ST_RD_LO:
        stateNext = ST_RD_HI;
      ST_RD_HI:
        stateNext = ST_WR_REQ;
      ST_RSP_WAIT:
        if (timedOut) stateNext = ST_DONE;
        else if (FlashRspDone) begin
          if (FlashRspFail || cmd[CMD_ER_BIT] || lastWord)
            stateNext = ST_DONE;
          else
            stateNext = ST_RD_LO;
        end
      ST_DONE:
        stateNext = ST_IDLE;
      default:
        stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cmd     <= '0;
      addrReg <= '0;
      lenReg  <= '0;
      idx     <= '0;
      loReg   <= '0;
      hiReg   <= '0;
      errReg  <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        cmd     <= {FlashOpEr, FlashOpWr};
        addrReg <= FlashOpAddr;
        lenReg  <= FlashOpLen;
        idx     <= '0;
        errReg  <= 1'b0;
      end
      if ((state == ST_CHECK) && cmdBad) errReg <= 1'b1;
      if (rspSeen && FlashRspFail) errReg <= 1'b1;
      if (timedOut) errReg <= 1'b1;
      if (rspSeen && !FlashRspFail) idx <= idx + 7'd1;
      if (state == ST_RD_HI) loReg <= BufRdData;
      if (state == ST_WR_REQ) hiReg <= BufRdData;
    end
  end

  // The RAM keeps returning entry 2i+1 while WR_REQ holds its address,
  // so the high half is taken live there and held afterwards.
  always_comb begin
    BufRdAddress = '0;
    unique case (1'b1)
      (state == ST_RD_LO):
        BufRdAddress = {idx[5:0], 1'b0};
      (state == ST_RD_HI),
      (state == ST_WR_REQ):
        BufRdAddress = {idx[5:0], 1'b1};
      default:
        BufRdAddress = '0;
    endcase
  end

  always_comb begin
    FlashReqAddr = '0;
    FlashReqType = REQ_WRITE;
    unique case (1'b1)
      (state == ST_ERASE_REQ): begin
        FlashReqAddr = addrReg;
        FlashReqType = REQ_ERASE;
      end
      (state == ST_WR_REQ):
        FlashReqAddr = addrReg + {11'd0, idx};
      default: begin
        FlashReqAddr = '0;
        FlashReqType = REQ_WRITE;
      end
    endcase
  end

  assign FlashReqData = {
    (state == ST_WR_REQ) ? BufRdData : hiReg,
    loReg
  };

  assign FlashReqValid = reqState && !timedOut;
  assign FlashCmdAck = accept;
  assign FlashBusy = state != ST_IDLE;
  assign FlashError = errReg;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Self-checking bench for flash_op_sequencer: table vectors, random
// commands against a word-list model, and hand-written corner sequences.
module tb_flash_op_sequencer;

  localparam int TMO = 50;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [17:0] FlashOpAddr;
  logic [5:0]  FlashOpLen;
  logic        FlashOpUnlock;
  logic        FlashOpWr;
  logic        FlashOpEr;
  logic        FlashCmdAck;
  logic        FlashBusy;
  logic        FlashError;
  logic [6:0]  BufRdAddress;
  logic [15:0] BufRdData;
  logic        FlashReqValid;
  logic        FlashReqType;
  logic [17:0] FlashReqAddr;
  logic [31:0] FlashReqData;
  logic        FlashReqReady;
  logic        FlashRspDone;
  logic        FlashRspFail;

  always #5 Clock = ~Clock;

  flash_op_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .FlashOpAddr  (FlashOpAddr),
    .FlashOpLen   (FlashOpLen),
    .FlashOpUnlock(FlashOpUnlock),
    .FlashOpWr    (FlashOpWr),
    .FlashOpEr    (FlashOpEr),
    .FlashCmdAck  (FlashCmdAck),
    .FlashBusy    (FlashBusy),
    .FlashError   (FlashError),
    .BufRdAddress (BufRdAddress),
    .BufRdData    (BufRdData),
    .FlashReqValid(FlashReqValid),
    .FlashReqType (FlashReqType),
    .FlashReqAddr (FlashReqAddr),
    .FlashReqData (FlashReqData),
    .FlashReqReady(FlashReqReady),
    .FlashRspDone (FlashRspDone),
    .FlashRspFail (FlashRspFail)
  );

  // Staging RAM: synchronous read, data one cycle after address.
  logic [15:0] mem [128];
  always @(posedge Clock) BufRdData <= mem[BufRdAddress];

  typedef struct {
    bit          typ;
    logic [17:0] addr;
    logic [31:0] data;
  } req_t;

  req_t gotQ[$];
  req_t expQ[$];

  // Flash slave knobs (written by the test only).
  int stallSet = 0;
  int rspLat = 1;
  int failAbs = -1;
  bit noRsp = 1'b0;
  bit spurDone = 1'b0;

  // Flash slave state (written by the slave only).
  int vWait = 0;
  int reqIdx = 0;
  int rspCnt = 0;
  int ackCnt = 0;
  bit rspPend = 1'b0;
  bit rspFailN = 1'b0;
  bit rspDoneR = 1'b0;
  bit rspFailR = 1'b0;

  assign FlashReqReady = (vWait >= stallSet);
  assign FlashRspDone = rspDoneR | spurDone;
  assign FlashRspFail = rspFailR;

  always @(posedge Clock) begin
    rspDoneR <= 1'b0;
    rspFailR <= 1'b0;
    if (FlashCmdAck) ackCnt <= ackCnt + 1;
    if (FlashReqValid && !FlashReqReady) vWait <= vWait + 1;
    else vWait <= 0;
    if (FlashReqValid && FlashReqReady) begin
      gotQ.push_back('{FlashReqType, FlashReqAddr, FlashReqData});
      rspPend <= !noRsp;
      rspCnt <= rspLat;
      rspFailN <= (reqIdx == failAbs);
      reqIdx <= reqIdx + 1;
    end else if (rspPend) begin
      if (rspCnt <= 1) begin
        rspDoneR <= 1'b1;
        rspFailR <= rspFailN;
        rspPend <= 1'b0;
      end else begin
        rspCnt <= rspCnt - 1;
      end
    end
  end

  int nChk = 0;
  int nFail = 0;
  bit modelErr = 1'b0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the list of flash requests a command should produce.
  task automatic model(input bit un, input bit wr, input bit er,
                       input logic [17:0] a, input logic [5:0] l,
                       input int fa, output bit ack);
    expQ.delete();
    ack = un && (wr || er);
    if (!ack) return;
    modelErr = 1'b0;
    if (wr && er) begin
      modelErr = 1'b1;
      return;
    end
    if (er) begin
      expQ.push_back('{1'b1, a, 32'h0});
      modelErr = (fa == 0);
      return;
    end
    if (l == 0 || int'(a) + int'(l) > 262144) begin
      modelErr = 1'b1;
      return;
    end
    for (int i = 0; i < int'(l); i++) begin
      expQ.push_back('{1'b0, a + 18'(i),
                       {mem[2*i+1], mem[2*i]}});
      if (i == fa) begin
        modelErr = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input bit un, input bit wr, input bit er,
                       input logic [17:0] a, input logic [5:0] l);
    @(negedge Clock);
    FlashOpUnlock = un;
    FlashOpWr = wr;
    FlashOpEr = er;
    FlashOpAddr = a;
    FlashOpLen = l;
    @(posedge Clock);
    #1;
    FlashOpUnlock = 1'b0;
    FlashOpWr = 1'b0;
    FlashOpEr = 1'b0;
  endtask

  task automatic waitIdle(input string nm);
    int cyc;
    cyc = 0;
    while (FlashBusy && cyc < 3000) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    check({nm, " finish"}, 64'(cyc < 3000), 64'd1);
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic runCmd(input string nm,
                        input bit un, input bit wr, input bit er,
                        input logic [17:0] a, input logic [5:0] l,
                        input int fa, input int st, input int lat,
                        output int nReq, output bit err);
    bit eAck;
    int base;
    int acks;
    int n;
    model(un, wr, er, a, l, fa, eAck);
    stallSet = st;
    rspLat = lat;
    failAbs = (fa < 0) ? -1 : reqIdx + fa;
    base = gotQ.size();
    acks = ackCnt;
    issue(un, wr, er, a, l);
    waitIdle(nm);
    check({nm, " ack"}, 64'(ackCnt - acks), 64'(eAck));
    nReq = gotQ.size() - base;
    check({nm, " nreq"}, 64'(nReq), 64'(expQ.size()));
    n = (nReq < expQ.size()) ? nReq : expQ.size();
    for (int i = 0; i < n; i++) begin
      check({nm, " type"}, 64'(gotQ[base+i].typ), 64'(expQ[i].typ));
      check({nm, " addr"}, 64'(gotQ[base+i].addr), 64'(expQ[i].addr));
      if (!expQ[i].typ)
        check({nm, " data"}, 64'(gotQ[base+i].data),
              64'(expQ[i].data));
    end
    err = FlashError;
    check({nm, " err"}, 64'(FlashError), 64'(modelErr));
  endtask

  typedef struct {
    string       nm;
    bit          un;
    bit          wr;
    bit          er;
    logic [17:0] a;
    logic [5:0]  l;
    int          fa;
    int          st;
    int          expN;
    bit          expErr;
  } vec_t;

  vec_t vt[10];

  initial begin
    int nReq;
    bit err;
    int bad;
    int base;
    int cyc;

    vt[0] = '{"wr2",      1, 1, 0, 18'h00100,  2, -1, 0,  2, 0};
    vt[1] = '{"erase",    1, 0, 1, 18'h02000,  5, -1, 1,  1, 0};
    vt[2] = '{"len0",     1, 1, 0, 18'h00100,  0, -1, 0,  0, 1};
    vt[3] = '{"ovf",      1, 1, 0, 18'h3FFF0, 32, -1, 0,  0, 1};
    vt[4] = '{"both",     1, 1, 1, 18'h00100,  4, -1, 0,  0, 1};
    vt[5] = '{"edge_ok",  1, 1, 0, 18'h3FFC1, 63, -1, 0, 63, 0};
    vt[6] = '{"edge_bad", 1, 1, 0, 18'h3FFC2, 63, -1, 0,  0, 1};
    vt[7] = '{"nolock",   0, 1, 0, 18'h00100,  4, -1, 0,  0, 1};
    vt[8] = '{"wrfail",   1, 1, 0, 18'h00200,  3,  1, 2,  2, 1};
    vt[9] = '{"erfail",   1, 0, 1, 18'h02000,  5,  0, 0,  1, 1};

    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;

    Reset = 1'b1;
    FlashOpUnlock = 1'b0;
    FlashOpWr = 1'b0;
    FlashOpEr = 1'b0;
    FlashOpAddr = '0;
    FlashOpLen = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst busy", 64'(FlashBusy), 64'd0);
    check("rst err", 64'(FlashError), 64'd0);
    check("rst valid", 64'(FlashReqValid), 64'd0);
    check("rst addr", 64'(FlashReqAddr), 64'd0);
    check("rst data", 64'(FlashReqData), 64'd0);
    check("rst bufaddr", 64'(BufRdAddress), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;

    foreach (vt[i]) begin
      runCmd(vt[i].nm, vt[i].un, vt[i].wr, vt[i].er, vt[i].a,
             vt[i].l, vt[i].fa, vt[i].st, 1, nReq, err);
      check({vt[i].nm, " tbl nreq"}, 64'(nReq), 64'(vt[i].expN));
      check({vt[i].nm, " tbl err"}, 64'(err), 64'(vt[i].expErr));
    end
    check("wr2 word0", 64'(gotQ[0].data), 64'h22221111);
    check("wr2 word1", 64'(gotQ[1].data), 64'h44443333);
    check("wr2 addr1", 64'(gotQ[1].addr), 64'h00101);

    // Error is sticky until the next accepted command.
    repeat (20) @(posedge Clock);
    #1;
    check("sticky hold", 64'(FlashError), 64'd1);
    issue(1'b0, 1'b0, 1'b1, 18'h00100, 6'd1);
    check("sticky ignored", 64'(FlashError), 64'd1);
    stallSet = 0;
    failAbs = -1;
    issue(1'b1, 1'b0, 1'b1, 18'h00300, 6'd1);
    check("err clr on ack", 64'(FlashError), 64'd0);
    waitIdle("clr");
    modelErr = 1'b0;

    // Lock held off for 100 cycles: nothing may happen.
    bad = 0;
    base = ackCnt;
    @(negedge Clock);
    FlashOpUnlock = 1'b0;
    FlashOpWr = 1'b1;
    FlashOpAddr = 18'h00100;
    FlashOpLen = 6'd2;
    repeat (100) begin
      @(posedge Clock);
      #1;
      if (FlashBusy || FlashReqValid || FlashCmdAck) bad++;
    end
    FlashOpWr = 1'b0;
    check("nolock 100 quiet", 64'(bad), 64'd0);
    check("nolock 100 ack", 64'(ackCnt - base), 64'd0);

    // Ready stall: request must stay stable; stray Done is ignored.
    stallSet = 5;
    rspLat = 1;
    failAbs = -1;
    base = gotQ.size();
    issue(1'b1, 1'b1, 1'b0, 18'h01234, 6'd1);
    cyc = 0;
    while (!FlashReqValid && cyc < 20) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    check("stall reach", 64'(cyc < 20), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall valid", 64'(FlashReqValid), 64'd1);
      check("stall addr", 64'(FlashReqAddr), 64'h01234);
      check("stall data", 64'(FlashReqData), 64'({mem[1], mem[0]}));
      spurDone = (k == 2);
      @(posedge Clock);
      #1;
      spurDone = 1'b0;
    end
    waitIdle("stall");
    check("stall nreq", 64'(gotQ.size() - base), 64'd1);
    check("stall err", 64'(FlashError), 64'd0);
    stallSet = 0;

    // Reset while waiting for a response.
    rspLat = 30;
    base = gotQ.size();
    issue(1'b1, 1'b1, 1'b0, 18'h00400, 6'd2);
    cyc = 0;
    while (gotQ.size() == base && cyc < 20) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    check("rspwait reach", 64'(cyc < 20), 64'd1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("mid rst busy", 64'(FlashBusy), 64'd0);
    check("mid rst outs",
          64'({FlashCmdAck, FlashError, FlashReqValid, FlashReqType}),
          64'd0);
    check("mid rst addr", 64'(FlashReqAddr), 64'd0);
    check("mid rst data", 64'(FlashReqData), 64'd0);
    check("mid rst bufaddr", 64'(BufRdAddress), 64'd0);
    Reset = 1'b0;
    base = gotQ.size();
    repeat (40) @(posedge Clock);
    #1;
    check("post rst idle", 64'(FlashBusy), 64'd0);
    check("post rst nreq", 64'(gotQ.size() - base), 64'd0);
    modelErr = 1'b0;

`ifdef FLASH_OP_TIMEOUT_EN
    noRsp = 1'b1;
    base = gotQ.size();
    issue(1'b1, 1'b0, 1'b1, 18'h00800, 6'd0);
    cyc = 0;
    while (gotQ.size() == base && cyc < 20) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    cyc = 0;
    while (FlashBusy && cyc < 200) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    check("tmo fall late", 64'(cyc <= TMO + 2), 64'd1);
    check("tmo fall early", 64'(cyc >= TMO), 64'd1);
    check("tmo err", 64'(FlashError), 64'd1);
    noRsp = 1'b0;
`endif

    // Random commands against the model.
    for (int it = 0; it < 40; it++) begin
      bit un;
      bit wr;
      bit er;
      logic [17:0] a;
      logic [5:0] l;
      int fa;
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      un = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 5))
        0: begin wr = 1; er = 1; end
        1, 2: begin wr = 0; er = 1; end
        default: begin wr = 1; er = 0; end
      endcase
      if ($urandom_range(0, 3) == 0)
        a = 18'h3FFC0 + 18'($urandom_range(0, 63));
      else
        a = 18'($urandom);
      if ($urandom_range(0, 7) == 0)
        l = 6'($urandom_range(40, 63));
      else
        l = 6'($urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0)
        fa = er ? 0 : $urandom_range(0, int'(l));
      else
        fa = -1;
      runCmd("rand", un, wr, er, a, l, fa,
             $urandom_range(0, 3), $urandom_range(1, 3), nReq, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
